// File: rtl/wave_cmd_pkg.sv
// wave_cmd_pkg: shared definitions for the waveform command controller.
//   - FSM state enumeration
//   - command / response byte constants
//   - register address map and CTRL / STATUS bit positions
//   - helper to render a state as a one-hot debug vector
package wave_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    EXEC     = 3'd3,
    SEND     = 3'd4,
    WAIT_TX  = 3'd5
  } state_t;

  // Frame command bytes and response bytes
  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_NAK = 8'h55;

  // Register map
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_FREQ_LO = 3'd1;
  localparam logic [2:0] ADDR_FREQ_HI = 3'd2;
  localparam logic [2:0] ADDR_AMPL    = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd7;

  // CTRL fields
  localparam int unsigned CTRL_RUN_BIT = 0;
  localparam int unsigned CTRL_SEL_LSB = 1;
  localparam int unsigned CTRL_SEL_MSB = 2;

  // STATUS sticky bits
  localparam int unsigned STATUS_OVR_BIT = 0;
  localparam int unsigned STATUS_TO_BIT  = 1;

  function automatic logic [7:0] state_onehot(input state_t s);
    logic [7:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wave_cmd_ctrl_regs.sv
// wave_cfg_regs: 8 x 8-bit configuration register bank for the waveform
// generator.
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  single-cycle register write
//   rd_addr -> rd_data  combinational read port
//   set_ovr, set_to     set the STATUS overrun / timeout sticky bits
//   wave_run, wave_sel  CTRL fields
//   freq_word           committed phase increment (FREQ_HI write commits)
//   ampl                amplitude register
module wave_cfg_regs
  import wave_cmd_pkg::*;
#(
  parameter logic [7:0] AMPL_RST = 8'h80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  input  logic        set_ovr,
  input  logic        set_to,
  output logic        wave_run,
  output logic [1:0]  wave_sel,
  output logic [15:0] freq_word,
  output logic [7:0]  ampl
);

  logic [7:0]  ctrl_q;
  logic [7:0]  shadow_lo_q;
  logic [15:0] freq_q;
  logic [7:0]  ampl_q;
  logic [7:0]  scratch4_q, scratch5_q, scratch6_q;
  logic        ovr_q, to_q;
  logic        status_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      shadow_lo_q <= '0;
      freq_q      <= '0;
      ampl_q      <= AMPL_RST;
      scratch4_q  <= '0;
      scratch5_q  <= '0;
      scratch6_q  <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_CTRL:    ctrl_q      <= wr_data;
        ADDR_FREQ_LO: shadow_lo_q <= wr_data;
        // Both halves land together so the generator never sees a torn word
        ADDR_FREQ_HI: freq_q      <= {wr_data, shadow_lo_q};
        ADDR_AMPL:    ampl_q      <= wr_data;
        3'd4:         scratch4_q  <= wr_data;
        3'd5:         scratch5_q  <= wr_data;
        3'd6:         scratch6_q  <= wr_data;
        default:      ;
      endcase
    end
  end

  assign status_wr = wr_en && (wr_addr == ADDR_STATUS);

  // Write-1-to-clear; a new event in the same cycle as a clear keeps the bit
  // set so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      ovr_q <= set_ovr | (ovr_q & ~(status_wr & wr_data[STATUS_OVR_BIT]));
      to_q  <= set_to  | (to_q  & ~(status_wr & wr_data[STATUS_TO_BIT]));
    end
  end

  // FREQ_LO/HI read back the committed word, never the shadow
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_CTRL:    rd_data = ctrl_q;
      ADDR_FREQ_LO: rd_data = freq_q[7:0];
      ADDR_FREQ_HI: rd_data = freq_q[15:8];
      ADDR_AMPL:    rd_data = ampl_q;
      3'd4:         rd_data = scratch4_q;
      3'd5:         rd_data = scratch5_q;
      3'd6:         rd_data = scratch6_q;
      ADDR_STATUS: begin
        rd_data[STATUS_OVR_BIT] = ovr_q;
        rd_data[STATUS_TO_BIT]  = to_q;
      end
      default:      rd_data = '0;
    endcase
  end

  assign wave_run  = ctrl_q[CTRL_RUN_BIT];
  assign wave_sel  = ctrl_q[CTRL_SEL_MSB:CTRL_SEL_LSB];
  assign freq_word = freq_q;
  assign ampl      = ampl_q;

endmodule

// File: rtl/wave_cmd_ctrl.sv
// wave_cmd_ctrl: byte-framed command parser between the UART transceiver and
// the waveform generator. Parses W addr data / R addr frames, drives the
// configuration register bank and returns one response byte per command.
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_done, rx_data   received byte strobe and data
//   tx_done            transmitter finished the current byte
//   tx_data, tx_wr     response byte and one-cycle transmit strobe
//   wave_run, wave_sel, freq_word, ampl   generator configuration
//   err_o              one-cycle pulse on overrun or inter-byte timeout
//   state_o            one-hot FSM state for debug LEDs
module wave_cmd_ctrl
  import wave_cmd_pkg::*;
#(
  parameter int unsigned FCLK        = 50000000,
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter logic [7:0]  AMPL_RST    = 8'h80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  output logic        wave_run,
  output logic [1:0]  wave_sel,
  output logic [15:0] freq_word,
  output logic [7:0]  ampl,
  output logic        err_o,
  output logic [7:0]  state_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);

  if (FCLK == 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("wave_cmd_ctrl: FCLK and TIMEOUT_CYC must be nonzero");
  end

  state_t           state_q, state_d;
  logic             cmd_wr_q;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] to_cnt_q;

  logic       rx_is_cmd;
  logic       in_frame;
  logic       timeout_hit;
  logic       overrun;
  logic       addr_ok;
  logic       reg_wr_en;
  logic [7:0] reg_rd_data;
  logic [7:0] exec_rsp;

  assign rx_is_cmd   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign in_frame    = (state_q == GET_ADDR) || (state_q == GET_DATA);
  // A byte arriving on the expiry cycle takes priority over the timeout
  assign timeout_hit = in_frame && !rx_done && (to_cnt_q == TO_MAX);
  assign overrun     = rx_done &&
                       ((state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX));
  assign addr_ok     = (addr_q[7:3] == '0);
  assign exec_rsp    = !addr_ok ? RSP_NAK : (cmd_wr_q ? RSP_ACK : reg_rd_data);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_done) state_d = rx_is_cmd ? GET_ADDR : SEND;
      end
      GET_ADDR: begin
        if (rx_done)          state_d = cmd_wr_q ? GET_DATA : EXEC;
        else if (timeout_hit) state_d = IDLE;
      end
      GET_DATA: begin
        if (rx_done)          state_d = EXEC;
        else if (timeout_hit) state_d = IDLE;
      end
      EXEC:    state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx_wr     = (state_q == SEND);
    reg_wr_en = (state_q == EXEC) && cmd_wr_q && addr_ok;
    state_o   = state_onehot(state_q);
  end

  // ---------------- frame capture, response, timeout, error ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_data  <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= overrun | timeout_hit;
      if (rx_done && (state_q == IDLE)) begin
        cmd_wr_q <= (rx_data == CMD_WR);
        // Unknown command byte: the NAK goes straight out without EXEC
        if (!rx_is_cmd) tx_data <= RSP_NAK;
      end
      if (rx_done && (state_q == GET_ADDR)) addr_q <= rx_data;
      if (rx_done && (state_q == GET_DATA)) data_q <= rx_data;
      if (state_q == EXEC) tx_data <= exec_rsp;
    end
  end

  // Inter-byte timer: runs only inside a frame, restarts on every byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!in_frame || rx_done) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  wave_cfg_regs #(
    .AMPL_RST (AMPL_RST)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (reg_wr_en),
    .wr_addr   (addr_q[2:0]),
    .wr_data   (data_q),
    .rd_addr   (addr_q[2:0]),
    .rd_data   (reg_rd_data),
    .set_ovr   (overrun),
    .set_to    (timeout_hit),
    .wave_run  (wave_run),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .ampl      (ampl)
  );

endmodule

// File: tb/tb_wave_cmd_ctrl.sv
// Self-checking bench for wave_cmd_ctrl: directed frames followed by random
// frames, compared against a register-map level reference model.
module tb_wave_cmd_ctrl;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        wave_run;
  logic [1:0]  wave_sel;
  logic [15:0] freq_word;
  logic [7:0]  ampl;
  logic        err_o;
  logic [7:0]  state_o;

  wave_cmd_ctrl #(
    .FCLK        (50000000),
    .TIMEOUT_CYC (TO),
    .AMPL_RST    (8'h80)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .wave_run  (wave_run),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .ampl      (ampl),
    .err_o     (err_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: the register map itself ----------------
  logic [7:0]  m_reg [8];
  logic [7:0]  m_shadow;
  logic [15:0] m_freq;
  logic        m_ovr, m_to;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_reg[3] = 8'h80;
    m_shadow = 8'h00;
    m_freq   = 16'h0000;
    m_ovr    = 1'b0;
    m_to     = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input int a);
    case (a)
      1:       return m_freq[7:0];
      2:       return m_freq[15:8];
      7:       return {6'b0, m_to, m_ovr};
      default: return m_reg[a];
    endcase
  endfunction

  task automatic model_write(input int a, input logic [7:0] d);
    case (a)
      1: m_shadow = d;
      2: m_freq = {d, m_shadow};
      7: begin
        if (d[0]) m_ovr = 1'b0;
        if (d[1]) m_to  = 1'b0;
      end
      default: m_reg[a] = d;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".run"},  wave_run,  m_reg[0][0]);
    check_eq({tag, ".sel"},  wave_sel,  m_reg[0][2:1]);
    check_eq({tag, ".freq"}, freq_word, m_freq);
    check_eq({tag, ".ampl"}, ampl,      m_reg[3]);
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit inject_ovr);
    int         nb, exp_lat, lat;
    logic [7:0] exp_rsp;
    if (b0 == 8'h57)      nb = 3;
    else if (b0 == 8'h52) nb = 2;
    else                  nb = 1;
    exp_lat = (nb == 1) ? 1 : 2;

    if (nb == 1)        exp_rsp = 8'h55;
    else if (b1 > 8'd7) exp_rsp = 8'h55;
    else if (nb == 3) begin
      model_write(int'(b1), b2);
      exp_rsp = 8'hAA;
    end else            exp_rsp = model_read(int'(b1));

    send_byte(b0);
    if (nb >= 2) begin
      idle_cycles($urandom_range(0, 3));
      send_byte(b1);
    end
    if (nb == 3) begin
      idle_cycles($urandom_range(0, 3));
      send_byte(b2);
    end

    lat = 1;
    while (!tx_wr && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("tx_latency", lat, exp_lat);
    check_eq("tx_data", tx_data, exp_rsp);
    check_outputs("regs");

    @(negedge clk);
    check_eq("tx_wr_pulse", tx_wr, 1'b0);

    if (inject_ovr) begin
      send_byte(8'h52);
      check_eq("ovr_err", err_o, 1'b1);
      m_ovr = 1'b1;
    end
    idle_cycles($urandom_range(0, 3));
    check_eq("tx_data_hold", tx_data, exp_rsp);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq("back_idle", state_o, 8'h01);
  endtask

  task automatic rd_frame(input logic [7:0] a);
    run_frame(8'h52, a, 8'h00, 1'b0);
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    run_frame(8'h57, a, d, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".state"}, state_o, 8'h01);
    check_eq({tag, ".tx_wr"}, tx_wr,   1'b0);
    check_eq({tag, ".tx_data"}, tx_data, 8'h00);
    check_eq({tag, ".err"},   err_o,   1'b0);
    check_outputs(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int         cnt;
    bit         saw_tx;
    logic [7:0] b0, b1, b2;
    int unsigned r;

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames
    rd_frame(8'h03);
    wr_frame(8'h00, 8'h05);
    check_eq("ctrl_run", wave_run, 1'b1);
    check_eq("ctrl_sel", wave_sel, 2'b10);
    wr_frame(8'h01, 8'h34);
    check_eq("freq_shadow_only", freq_word, 16'h0000);
    wr_frame(8'h02, 8'h12);
    check_eq("freq_commit", freq_word, 16'h1234);
    rd_frame(8'h01);
    run_frame(8'h41, 8'h00, 8'h00, 1'b0);
    run_frame(8'h57, 8'h09, 8'hFF, 1'b0);

    // Inter-byte timeout with a partial write frame
    send_byte(8'h57);
    send_byte(8'h03);
    cnt = 1;
    saw_tx = 1'b0;
    while (!err_o && cnt < int'(TO) + 20) begin
      @(negedge clk);
      cnt++;
      if (tx_wr) saw_tx = 1'b1;
    end
    check_eq("timeout_cycle", cnt, TO + 2);
    check_eq("timeout_no_tx", saw_tx, 1'b0);
    m_to = 1'b1;
    @(negedge clk);
    check_eq("timeout_idle", state_o, 8'h01);
    check_eq("timeout_err_pulse", err_o, 1'b0);
    check_outputs("timeout");
    rd_frame(8'h07);
    wr_frame(8'h07, 8'h02);
    rd_frame(8'h07);

    // Overrun during WAIT_TX, then normal frames
    run_frame(8'h52, 8'h03, 8'h00, 1'b1);
    rd_frame(8'h07);
    wr_frame(8'h04, 8'h5A);
    rd_frame(8'h04);

    // tx_done outside WAIT_TX is ignored
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq("stray_tx_done", state_o, 8'h01);

    // Reset while in GET_DATA
    send_byte(8'h57);
    send_byte(8'h04);
    check_eq("pre_reset_state", state_o, 8'h04);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_frame(8'h03);

    // Random frames
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      b1 = 8'($urandom_range(0, 9));
      b2 = 8'($urandom);
      if (r < 4)      b0 = 8'h57;
      else if (r < 8) b0 = 8'h52;
      else begin
        b0 = 8'($urandom);
        while (b0 == 8'h57 || b0 == 8'h52) b0 = 8'($urandom);
      end
      run_frame(b0, b1, b2, ($urandom_range(0, 7) == 0));
      idle_cycles($urandom_range(0, 4));
    end
    for (int a = 0; a < 8; a++) rd_frame(8'(a));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_cmd_ctrl.md
Name: wave_cmd_ctrl

Overview:
Command controller between the UART transceiver and the waveform generator datapath. It parses byte-framed read/write commands from rx bytes and maintains an 8-entry x 8-bit configuration register bank that drives the generator. It returns one response byte per command through the transceiver's tx_wr/tx_done handshake. It replaces the ad-hoc echo logic in the digital core top level.

Parameters:
FCLK, 50000000, system clock frequency in Hz.
TIMEOUT_CYC, 2500000, inter-byte timeout in clk cycles (50 ms at 50 MHz); counter width is $clog2(TIMEOUT_CYC+1).
AMPL_RST, 8'h80, reset value of the amplitude register.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_done  in  1  one-cycle pulse; rx_data is valid on this cycle
rx_data  in  8  received byte
tx_done  in  1  one-cycle pulse; the transmitter has finished the byte
tx_data  out  8  response byte; stable from tx_wr until tx_done
tx_wr  out  1  one-cycle transmit strobe
wave_run  out  1  generator enable (CTRL[0])
wave_sel  out  2  waveform select (CTRL[2:1])
freq_word  out  16  phase increment; committed atomically
ampl  out  8  amplitude (reg3)
err_o  out  1  one-cycle pulse on overrun or timeout
state_o  out  8  one-hot FSM state, for debug LEDs

Behaviour:
- Reset values (asynchronous, active-low): all registers 0 except reg3 = AMPL_RST. tx_wr=0, tx_data=0, err_o=0, freq_word=0. FSM enters IDLE.
- Command frames:
  - Write: 8'h57, addr, data. Response 8'hAA on success.
  - Read: 8'h52, addr. Response is reg[addr].
  - Any other first byte: response NAK 8'h55.
  - addr > 7: response NAK 8'h55 and no write. For a write with a bad addr, the data byte is still consumed before the NAK is sent.
- Register map:
  - reg0 CTRL.
  - reg1 FREQ_LO. Writes go to a shadow register only.
  - reg2 FREQ_HI. A write sets freq_word <= {data, shadow_lo} in one cycle.
  - reg3 AMPL.
  - reg4-6 scratch.
  - reg7 STATUS: bit0 overrun sticky, bit1 timeout sticky. Writing 1 clears the corresponding bit. Writing 0 has no effect. Other bits read 0.
- Reads of reg1 return the committed freq_word[7:0], not the shadow.
- FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_TX.
  - IDLE: on rx_done with W or R -> GET_ADDR. On any other byte -> latch NAK -> SEND.
  - GET_ADDR: on rx_done with W -> GET_DATA. With R -> EXEC.
  - GET_DATA: on rx_done -> EXEC.
  - EXEC (1 cycle): perform the write or fetch the read data, select the response byte -> SEND.
  - SEND (1 cycle): tx_wr=1 with tx_data valid -> WAIT_TX.
  - WAIT_TX: on tx_done -> IDLE.
- Latency:
  - tx_wr asserts exactly 2 cycles after the rx_done of the final frame byte (EXEC, then SEND).
  - A written register is visible on the outputs on the cycle after EXEC.
  - For a NAK on the first byte, tx_wr asserts 1 cycle after rx_done.
- Timeout:
  - In GET_ADDR or GET_DATA, the counter resets on each rx_done.
  - When the counter reaches TIMEOUT_CYC: discard the partial frame, set the timeout sticky, pulse err_o, go to IDLE. No response is sent.
- Overrun:
  - rx_done during EXEC, SEND or WAIT_TX: drop the byte, set the overrun sticky, pulse err_o. The FSM is unaffected.
- Simultaneous events:
  - rx_done and timeout expiry in the same cycle: rx_done wins and the counter reloads.
  - tx_done in any state other than WAIT_TX is ignored.
- Reset mid-frame or mid-transmission returns to IDLE with tx_wr low. The byte already handed to the transmitter is not tracked.

Decomposition:
- Package wave_cmd_pkg contains:
  - state enum: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_TX
  - command, ACK and NAK byte constants
  - register address constants: CTRL, FREQ_LO, FREQ_HI, AMPL, STATUS
  - CTRL bit-field positions
- One natural sub-module, wave_cfg_regs: the register bank, freq shadow/commit logic and STATUS write-1-to-clear logic. The FSM, timeout counter and handshake stay in wave_cmd_ctrl.

Test Plan:
- Frame 57 00 05: CTRL=05, wave_run=1, wave_sel=2'b10. tx_wr pulses 2 cycles after the 3rd rx_done with tx_data=AA. Then tx_done; state_o returns to IDLE.
- Frame 57 01 34: freq_word stays 0000. Then frame 57 02 12: freq_word becomes 1234 in a single cycle. Frame 52 01 returns 34.
- Frame 52 03 after reset returns 80. Frame 41 returns 55 with no register change. Frame 57 09 FF returns 55 and the bank is unchanged.
- Frame 57 03 then silence for TIMEOUT_CYC cycles (bench uses TIMEOUT_CYC=100): err_o pulses, no tx_wr. Frame 52 07 returns 02. Frame 57 07 02 clears it; a following 52 07 returns 00.
- Extra rx_done during WAIT_TX: err_o pulses, the byte is not parsed, STATUS[0]=1, and the next frame is handled normally.
- Assert rst_n low during GET_DATA, then release: all outputs at reset values, and the next frame 52 03 returns 80.
